// File: rtl/enigma_encoder_if.sv
// Character handshake, settings load and rotor-position bundle for the Enigma encoder.
// The master drives plaintext and settings; the slave returns ciphertext and positions.
interface enigma_encoder_if;
    logic        load_settings;
    logic [14:0] rotor_start;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_out;
    logic        out_valid;
    logic [14:0] rotor_pos;

    modport master (
        output load_settings, rotor_start, char_in, char_valid,
        input  char_ready, char_out, out_valid, rotor_pos
    );

    modport slave (
        input  load_settings, rotor_start, char_in, char_valid,
        output char_ready, char_out, out_valid, rotor_pos
    );
endinterface

// File: rtl/enigma_encoder.sv
// Enigma I encryptor: rotors I-II-III, reflector B, rings AAA, no plugboard.
// One substitution per cycle through a shared lookup unit; non-letters bypass the rotors.
module enigma_encoder (
    input  logic            clk,
    input  logic            reset,
    enigma_encoder_if.slave bus
);

    // Strings pack letter 0 into the most significant byte.
    localparam logic [207:0] WireI     = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] WireII    = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] WireIII   = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] ReflB     = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    localparam logic [207:0] InvI      = "UWYGADFPVZBECKMTHXSLRINQOJ";
    localparam logic [207:0] InvII     = "AJPCZWRLFBDKOTYUQGENHXMIVS";
    localparam logic [207:0] InvIII    = "TAGBPCSDQEUFVNZHYIXJWLRKOM";

    localparam logic [4:0] NotchI   = 5'd16;
    localparam logic [4:0] NotchII  = 5'd4;
    localparam logic [4:0] NotchIII = 5'd21;

    typedef enum logic [3:0] {
        StIdle, StStep, StFr, StFm, StFl, StRefl, StBl, StBm, StBr, StDone
    } state_e;

    typedef enum logic [2:0] {
        TblIFwd, TblIIFwd, TblIIIFwd, TblRefl, TblIInv, TblIIInv, TblIIIInv
    } tbl_e;

    function automatic logic [4:0] mod_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return 5'(s);
    endfunction

    function automatic logic [4:0] mod_sub(input logic [4:0] a, input logic [4:0] b);
        if (a >= b) return a - b;
        return 5'(6'(a) + 6'd26 - 6'(b));
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    function automatic logic [4:0] clamp26(input logic [4:0] a);
        return (a >= 5'd26) ? 5'd0 : a;
    endfunction

    function automatic logic [4:0] rom_lookup(input tbl_e sel, input logic [4:0] idx);
        logic [207:0] tbl;
        logic [7:0]   lo;
        case (sel)
            TblIFwd:   tbl = WireI;
            TblIIFwd:  tbl = WireII;
            TblIIIFwd: tbl = WireIII;
            TblIInv:   tbl = InvI;
            TblIIInv:  tbl = InvII;
            TblIIIInv: tbl = InvIII;
            default:   tbl = ReflB;
        endcase
        lo = {5'd25 - idx, 3'b000};
        return 5'(tbl[lo +: 8] - 8'h41);
    endfunction

    state_e      state_q, state_d;
    logic [14:0] pos_q, pos_d;
    logic [4:0]  letter_q, letter_d;
    logic [7:0]  char_out_q, char_out_d;

    logic [4:0]  pos_l, pos_m, pos_r;
    tbl_e        tbl_sel;
    logic [4:0]  sub_pos;
    logic [4:0]  sub_out;
    logic        is_upper, is_lower;

    assign pos_l = pos_q[14:10];
    assign pos_m = pos_q[9:5];
    assign pos_r = pos_q[4:0];

    assign is_upper = (bus.char_in >= 8'h41) && (bus.char_in <= 8'h5A);
    assign is_lower = (bus.char_in >= 8'h61) && (bus.char_in <= 8'h7A);

    always_comb begin
        tbl_sel = TblRefl;
        sub_pos = 5'd0;
        case (state_q)
            StFr:    begin tbl_sel = TblIIIFwd; sub_pos = pos_r; end
            StFm:    begin tbl_sel = TblIIFwd;  sub_pos = pos_m; end
            StFl:    begin tbl_sel = TblIFwd;   sub_pos = pos_l; end
            StBl:    begin tbl_sel = TblIInv;   sub_pos = pos_l; end
            StBm:    begin tbl_sel = TblIIInv;  sub_pos = pos_m; end
            StBr:    begin tbl_sel = TblIIIInv; sub_pos = pos_r; end
            default: begin tbl_sel = TblRefl;   sub_pos = 5'd0;  end
        endcase
    end

    assign sub_out = mod_sub(rom_lookup(tbl_sel, mod_add(letter_q, sub_pos)), sub_pos);

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        letter_d   = letter_q;
        char_out_d = char_out_q;
        case (state_q)
            StIdle: begin
                if (bus.load_settings) begin
                    pos_d = {clamp26(bus.rotor_start[14:10]), clamp26(bus.rotor_start[9:5]),
                             clamp26(bus.rotor_start[4:0])};
                end else if (bus.char_valid) begin
                    if (is_upper) begin
                        letter_d = 5'(bus.char_in - 8'h41);
                        state_d  = StStep;
                    end else if (is_lower) begin
                        letter_d = 5'(bus.char_in - 8'h61);
                        state_d  = StStep;
                    end else begin
                        char_out_d = bus.char_in;
                        state_d    = StDone;
                    end
                end
            end
            StStep: begin
                // Notch tests use pre-step positions; middle at its notch double-steps.
                pos_d[4:0] = inc26(pos_r);
                if (pos_r == NotchIII || pos_m == NotchII) pos_d[9:5] = inc26(pos_m);
                if (pos_m == NotchII) pos_d[14:10] = inc26(pos_l);
                state_d = StFr;
            end
            StFr:   begin letter_d = sub_out; state_d = StFm;   end
            StFm:   begin letter_d = sub_out; state_d = StFl;   end
            StFl:   begin letter_d = sub_out; state_d = StRefl; end
            StRefl: begin letter_d = sub_out; state_d = StBl;   end
            StBl:   begin letter_d = sub_out; state_d = StBm;   end
            StBm:   begin letter_d = sub_out; state_d = StBr;   end
            StBr: begin
                letter_d   = sub_out;
                char_out_d = 8'h41 + {3'b000, sub_out};
                state_d    = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pos_q      <= 15'd0;
            letter_q   <= 5'd0;
            char_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            letter_q   <= letter_d;
            char_out_q <= char_out_d;
        end
    end

    // NotchI is documentation only: nothing to the left of rotor I is stepped.
    localparam logic [4:0] UnusedNotch = NotchI;

    assign bus.char_ready = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.char_out   = char_out_q;
    assign bus.rotor_pos  = pos_q;

endmodule
